// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies.
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;
    localparam logic [3:0] MD_MSUBU = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int MD_MUL_LAT = 5;
    localparam int MD_DIV_LAT = 10;
    localparam int MD_CNT_W   = 4;

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath producing the pending {HI, LO}.
// Define MD_UNIT_MADD_EN to add madd/maddu/msub/msubu (accumulate into HI/LO).
module md_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] p_hi,
    output logic [WIDTH-1:0] p_lo,
    output logic             div_zero,
    output logic             launch,
    output logic             is_div
);

    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic        [WIDTH-1:0]   b_safe, a_mag, b_mag_raw, b_mag;
    logic        [WIDTH-1:0]   uq, ur, sq, sr, s_quo, s_rem;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // A zero divisor is replaced by one so the divider never sees x; the
    // result is discarded at commit anyway.
    assign b_safe = (b == '0) ? WIDTH'(1) : b;
    assign uq     = a / b_safe;
    assign ur     = a % b_safe;

    // Signed divide on magnitudes; MIN / -1 falls out as LO=MIN, HI=0.
    assign a_mag     = a[WIDTH-1] ? -a : a;
    assign b_mag_raw = b[WIDTH-1] ? -b : b;
    assign b_mag     = (b == '0) ? WIDTH'(1) : b_mag_raw;
    assign sq        = a_mag / b_mag;
    assign sr        = a_mag % b_mag;
    assign s_quo     = (a[WIDTH-1] ^ b[WIDTH-1]) ? -sq : sq;
    assign s_rem     = a[WIDTH-1] ? -sr : sr;

    assign div_zero = is_div && (b == '0);

    always_comb begin
        p_hi   = hi;
        p_lo   = lo;
        launch = 1'b0;
        is_div = 1'b0;
        case (op)
            MD_MULT: begin
                {p_hi, p_lo} = prod_s;
                launch       = 1'b1;
            end
            MD_MULTU: begin
                {p_hi, p_lo} = prod_u;
                launch       = 1'b1;
            end
            MD_DIV: begin
                p_lo   = s_quo;
                p_hi   = s_rem;
                launch = 1'b1;
                is_div = 1'b1;
            end
            MD_DIVU: begin
                p_lo   = uq;
                p_hi   = ur;
                launch = 1'b1;
                is_div = 1'b1;
            end
`ifdef MD_UNIT_MADD_EN
            MD_MADD: begin
                {p_hi, p_lo} = {hi, lo} + prod_s;
                launch       = 1'b1;
            end
            MD_MADDU: begin
                {p_hi, p_lo} = {hi, lo} + prod_u;
                launch       = 1'b1;
            end
            MD_MSUB: begin
                {p_hi, p_lo} = {hi, lo} - prod_s;
                launch       = 1'b1;
            end
            MD_MSUBU: begin
                {p_hi, p_lo} = {hi, lo} - prod_u;
                launch       = 1'b1;
            end
`endif
            MD_NONE: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; Busy covers the fixed latency.
// Optional accumulate ops are enabled with MD_UNIT_MADD_EN (see md_calc).
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = MD_MUL_LAT,
    parameter int DIV_LAT = MD_DIV_LAT,
    parameter int CNT_W   = MD_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       MD_Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] p_hi_q, p_lo_q;
    logic             dz_q;

    logic [WIDTH-1:0] calc_hi, calc_lo;
    logic             calc_dz, calc_launch, calc_is_div;

    md_calc #(.WIDTH(WIDTH)) u_calc (
        .op       (MD_Op),
        .a        (SrcA),
        .b        (SrcB),
        .hi       (HI),
        .lo       (LO),
        .p_hi     (calc_hi),
        .p_lo     (calc_lo),
        .div_zero (calc_dz),
        .launch   (calc_launch),
        .is_div   (calc_is_div)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            Busy   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
            p_hi_q <= '0;
            p_lo_q <= '0;
            dz_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        if (calc_launch) begin
                            p_hi_q <= calc_hi;
                            p_lo_q <= calc_lo;
                            dz_q   <= calc_dz;
                            cnt    <= calc_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                            Busy   <= 1'b1;
                            state  <= ST_BUSY;
                        end else if (MD_Op == MD_MTHI) begin
                            HI <= SrcA;
                        end else if (MD_Op == MD_MTLO) begin
                            LO <= SrcA;
                        end
                    end
                end
                // Start is not looked at here, so a stalled pipeline cannot
                // disturb the op in flight.
                ST_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        if (!dz_q) begin
                            HI <= p_hi_q;
                            LO <= p_lo_q;
                        end
                        cnt   <= '0;
                        Busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: reference model feeds an expected queue,
// compared when each op retires. Covers MD_UNIT_MADD_EN when defined.
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  MD_Op;
    logic [31:0] SrcA, SrcB;
    logic        Busy;
    logic [31:0] HI, LO;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    always #5 clk = ~clk;

    md_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MD_Op (MD_Op),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour computed with native 64-bit / int arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output int lat);
        longint      sa, sb;
        logic [63:0] p;
        int          qa, qb;
        eh  = m_hi;
        el  = m_lo;
        lat = 0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        case (op)
            4'd1: begin p = sa * sb; {eh, el} = p; lat = 5; end
            4'd2: begin p = {32'h0, a} * {32'h0, b}; {eh, el} = p; lat = 5; end
            4'd3: begin
                lat = 10;
                if (b != 32'h0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        el = 32'h8000_0000;
                        eh = 32'h0;
                    end else begin
                        qa = $signed(a);
                        qb = $signed(b);
                        el = 32'(qa / qb);
                        eh = 32'(qa % qb);
                    end
                end
            end
            4'd4: begin
                lat = 10;
                if (b != 32'h0) begin
                    el = a / b;
                    eh = a % b;
                end
            end
            4'd5: eh = a;
            4'd6: el = a;
`ifdef MD_UNIT_MADD_EN
            4'd7:  begin p = {m_hi, m_lo} + 64'(sa * sb); {eh, el} = p; lat = 5; end
            4'd8:  begin p = {m_hi, m_lo} + {32'h0, a} * {32'h0, b}; {eh, el} = p; lat = 5; end
            4'd9:  begin p = {m_hi, m_lo} - 64'(sa * sb); {eh, el} = p; lat = 5; end
            4'd10: begin p = {m_hi, m_lo} - {32'h0, a} * {32'h0, b}; {eh, el} = p; lat = 5; end
`endif
            default: ;
        endcase
    endtask

    // Drives one op; with hold=1 Start stays high (op hold_op, data 0x55)
    // through every busy cycle including the edge where Busy falls.
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic hold, input logic [3:0] hold_op);
        logic [31:0] eh, el;
        logic [63:0] e;
        int          lat, n;
        model(op, a, b, eh, el, lat);
        exp_q.push_back({eh, el});
        Start = 1'b1;
        MD_Op = op;
        SrcA  = a;
        SrcB  = b;
        @(posedge clk); #1;
        if (hold && lat != 0) begin
            MD_Op = hold_op;
            SrcA  = 32'h55;
            SrcB  = 32'h0;
        end else begin
            Start = 1'b0;
        end
        if (lat != 0) check({tag, ".hilo_stable"}, {HI, LO}, {m_hi, m_lo});
        n = 0;
        while (Busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        Start = 1'b0;
        check({tag, ".busy_cycles"}, 64'(n), 64'(lat));
        e = exp_q.pop_front();
        check({tag, ".hilo"}, {HI, LO}, e);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        MD_Op = 4'd0;
        SrcA  = 32'h0;
        SrcB  = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("reset.busy", 64'(Busy), 64'd0);
        check("reset.hi", 64'(HI), 64'd0);
        check("reset.lo", 64'(LO), 64'd0);

        issue("mtlo", MD_MTLO, 32'h0000_ABCD, 32'h0, 1'b0, 4'd0);
        check("mtlo.busy", 64'(Busy), 64'd0);
        issue("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 4'd0);
        issue("divu_7_2", MD_DIVU, 32'd7, 32'd2, 1'b0, 4'd0);
        issue("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 4'd0);

        issue("mult_hold_mthi", MD_MULT, 32'd3, 32'd4, 1'b1, MD_MTHI);
        issue("divu_hold_mtlo", MD_DIVU, 32'd100, 32'd9, 1'b1, MD_MTLO);

        issue("mthi_11", MD_MTHI, 32'h11, 32'h0, 1'b0, 4'd0);
        issue("mtlo_22", MD_MTLO, 32'h22, 32'h0, 1'b0, 4'd0);
        issue("div_by_zero", MD_DIV, 32'd5, 32'd0, 1'b0, 4'd0);
        issue("divu_by_zero", MD_DIVU, 32'd9, 32'd0, 1'b0, 4'd0);

        // Reset three cycles into a divide: immediate clear, no late commit.
        Start = 1'b1; MD_Op = MD_DIV; SrcA = 32'd100; SrcB = 32'd7;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("abort.busy_before", 64'(Busy), 64'd1);
        reset = 1'b1;
        #1;
        check("abort.busy", 64'(Busy), 64'd0);
        check("abort.hilo", {HI, LO}, 64'd0);
        #2 reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("abort.no_commit", {HI, LO}, 64'd0);
        check("abort.busy_after", 64'(Busy), 64'd0);
        m_hi = 32'h0;
        m_lo = 32'h0;

        issue("mthi_1234", MD_MTHI, 32'h1234, 32'h0, 1'b0, 4'd0);
        issue("mtlo_5678", MD_MTLO, 32'h5678, 32'h0, 1'b0, 4'd0);
        issue("op_none", MD_NONE, 32'hDEAD, 32'hBEEF, 1'b0, 4'd0);
        issue("op_11", 4'd11, 32'hDEAD, 32'hBEEF, 1'b0, 4'd0);
        issue("op_15", 4'd15, 32'hDEAD, 32'hBEEF, 1'b0, 4'd0);
        for (int k = 7; k <= 10; k++) begin
            issue("op_acc", 4'(k), 32'd2, 32'd3, 1'b0, 4'd0);
        end

        issue("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 4'd0);
        issue("div_7_m2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 4'd0);
        issue("div_m7_m2", MD_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 4'd0);
        issue("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd0);
        issue("mult_min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 4'd0);

        for (int i = 0; i < 10; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(1, 4));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            issue("rand", op, a, b, 1'b0, 4'd0);
        end

`ifdef MD_UNIT_MADD_EN
        issue("madd_mthi0", MD_MTHI, 32'h0, 32'h0, 1'b0, 4'd0);
        issue("madd_mtlo10", MD_MTLO, 32'd10, 32'h0, 1'b0, 4'd0);
        issue("madd_2x3", MD_MADD, 32'd2, 32'd3, 1'b0, 4'd0);
        check("madd.lo16", 64'(LO), 64'd16);
        issue("msub_neg", MD_MSUB, 32'hFFFF_FFFF, 32'd20, 1'b0, 4'd0);
        issue("maddu_big", MD_MADDU, 32'hFFFF_FFFF, 32'h2, 1'b0, 4'd0);
        issue("msubu_big", MD_MSUBU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
